// File: rtl/tdm_demux_pkg.sv
// Shared types and constants for the 4-slot TDM demultiplexer.
// No logic; constants only.
// No flow control; consumed by the counter and demux top.
package tdm_demux_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  localparam logic [SLOT_W-1:0] SLOT0 = SLOT_W'(0);
  localparam logic [SLOT_W-1:0] SLOT1 = SLOT_W'(1);
  localparam logic [SLOT_W-1:0] SLOT2 = SLOT_W'(2);
  localparam logic [SLOT_W-1:0] SLOT3 = SLOT_W'(NUM_SLOTS - 1);

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter: load-to-1 on an accepted sync, increment per data beat, clear on frame completion.
// Latency: new index visible one cycle after the controlling beat.
// No backpressure; the index simply holds while no control input is active.
module tdm_slot_counter
  import tdm_demux_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_inc,
  input  logic              i_clr,
  output logic [SLOT_W-1:0] o_slot,
  output logic              o_c1,
  output logic              o_c0,
  output logic              o_last
);

  logic [SLOT_W-1:0] r_slot;

  // Completion wins over a new sync so the index only wraps 3->0 at end of frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot <= SLOT0;
    end else if (i_clr) begin
      r_slot <= SLOT0;
    end else if (i_load) begin
      r_slot <= SLOT1;
    end else if (i_inc) begin
      r_slot <= r_slot + SLOT_W'(1);
    end
  end

  assign o_slot = r_slot;
  assign o_c1   = r_slot[1];
  assign o_c0   = r_slot[0];
  assign o_last = (r_slot == SLOT3);

endmodule

// File: rtl/tdm_demux4.sv
// 4-slot TDM demultiplexer: shadows slots 0..2, publishes all four lanes together on the slot-3 beat.
// Latency: x0..x3 and frame_valid appear one cycle after the slot-3 beat.
// No backpressure; valid_in low stalls the frame indefinitely, early sync discards the partial frame.
module tdm_demux4
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] m_in,
  input  logic             valid_in,
  input  logic             sync_in,
  output logic [WIDTH-1:0] x0,
  output logic [WIDTH-1:0] x1,
  output logic [WIDTH-1:0] x2,
  output logic [WIDTH-1:0] x3,
  output logic             c1,
  output logic             c0,
  output logic             frame_valid,
  output logic             frame_err
);

  state_t            r_state;
  logic [WIDTH-1:0]  r_sh0, r_sh1, r_sh2;
  logic [WIDTH-1:0]  r_x0, r_x1, r_x2, r_x3;
  logic              r_fv, r_fe;

  logic [SLOT_W-1:0] w_slot;
  logic              w_last;
  logic              w_data_beat;
  logic              w_load, w_inc, w_clr;

  // A sync beat always starts a new frame, in HUNT or (as an early sync) in COLLECT.
  assign w_data_beat = (r_state == COLLECT) && valid_in && !sync_in;
  assign w_load      = valid_in && sync_in;
  assign w_clr       = w_data_beat && w_last;
  assign w_inc       = w_data_beat && !w_last;

  tdm_slot_counter u_slot_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_inc  (w_inc),
    .i_clr  (w_clr),
    .o_slot (w_slot),
    .o_c1   (c1),
    .o_c0   (c0),
    .o_last (w_last)
  );

  // Frame FSM with shadow capture, output publish and one-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HUNT;
      r_sh0   <= '0;
      r_sh1   <= '0;
      r_sh2   <= '0;
      r_x0    <= '0;
      r_x1    <= '0;
      r_x2    <= '0;
      r_x3    <= '0;
      r_fv    <= 1'b0;
      r_fe    <= 1'b0;
    end else begin
      r_fv <= 1'b0;
      r_fe <= 1'b0;
      case (r_state)
        HUNT: begin
          // Unsynced beats are dropped silently while looking for slot 0.
          if (valid_in && sync_in) begin
            r_sh0   <= m_in;
            r_state <= COLLECT;
          end
        end
        COLLECT: begin
          if (valid_in) begin
            if (sync_in) begin
              // Early sync: drop the partial frame, restart with this beat as slot 0.
              r_fe  <= 1'b1;
              r_sh0 <= m_in;
            end else if (w_last) begin
              // Slot 3 goes straight to x3; all lanes update on the same edge.
              r_x0    <= r_sh0;
              r_x1    <= r_sh1;
              r_x2    <= r_sh2;
              r_x3    <= m_in;
              r_fv    <= 1'b1;
              r_state <= HUNT;
            end else if (w_slot == SLOT1) begin
              r_sh1 <= m_in;
            end else begin
              r_sh2 <= m_in;
            end
          end
        end
        default: r_state <= HUNT;
      endcase
    end
  end

  assign x0          = r_x0;
  assign x1          = r_x1;
  assign x2          = r_x2;
  assign x3          = r_x3;
  assign frame_valid = r_fv;
  assign frame_err   = r_fe;

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive end of the 4:1 mux path: a time-division demultiplexer.
- A single serial lane carries frames of four slots. Slot 0 is marked by sync_in.
- The block counts slots and captures each slot into a shadow register. When a frame completes, it updates all four outputs at once and pulses frame_valid.
- It sits after the mux/serialiser and drives the four parallel consumers.

Parameters:
- WIDTH, 1, data width of each slot and of each output lane.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- m_in  input  WIDTH  serial slot data.
- valid_in  input  1  m_in and sync_in are valid this cycle.
- sync_in  input  1  beat is slot 0 (start of frame); sampled only when valid_in=1.
- x0  output  WIDTH  slot 0 of the last complete frame.
- x1  output  WIDTH  slot 1 of the last complete frame.
- x2  output  WIDTH  slot 2 of the last complete frame.
- x3  output  WIDTH  slot 3 of the last complete frame.
- c1  output  1  MSB of the expected next slot index.
- c0  output  1  LSB of the expected next slot index.
- frame_valid  output  1  one-cycle pulse when x0..x3 have just updated.
- frame_err  output  1  one-cycle pulse when a partial frame is discarded.

Behaviour:
- Reset values:
  - rst_n=0 is asynchronous, one clock, reset active-low.
  - x0..x3=0, c1c0=00, frame_valid=0, frame_err=0, shadow regs=0, state=HUNT.
- State machine with two states, HUNT and COLLECT. Everything is registered; there are no combinational paths from inputs to outputs.
- HUNT:
  - valid_in=1, sync_in=1: shadow0<=m_in, slot<=1, go to COLLECT.
  - valid_in=1, sync_in=0: beat ignored, no error, stay in HUNT.
  - valid_in=0: hold.
- COLLECT:
  - valid_in=0: stall. Slot and shadow regs hold, with no timeout.
  - valid_in=1, sync_in=0, slot in 1..2: shadow[slot]<=m_in, slot<=slot+1.
  - valid_in=1, sync_in=0, slot=3 (frame complete):
    - x0..x2<=shadow0..2 and x3<=m_in, all on the same edge.
    - frame_valid=1 for exactly that next cycle.
    - slot<=0, go to HUNT.
  - valid_in=1, sync_in=1 at any slot 1..3 (early sync):
    - frame_err=1 for one cycle; the partial frame is discarded and x0..x3 are unchanged.
    - The beat is taken as the new slot 0: shadow0<=m_in, slot<=1, stay in COLLECT.
- Back-to-back frames: a sync beat on the cycle immediately after the slot-3 beat is accepted with no bubble. Sustained throughput is one frame per 4 valid beats.
- Latency: x0..x3 and frame_valid change on the clock edge that samples the slot-3 beat, so they are visible 1 cycle after that beat.
- x0..x3 hold their value between frames, indefinitely.
- c1c0 reflects the expected next slot index: 00 in HUNT, and the slot counter value in COLLECT. Slot index wraps 3->0 only through frame completion.
- Reset mid-frame discards the partial frame. The outputs return to the reset values, and the next frame must start with sync.
- frame_valid and frame_err are never asserted in the same cycle.

Decomposition:
- Package tdm_demux_pkg holds:
  - NUM_SLOTS=4 and SLOT_W=2;
  - the state typedef {HUNT, COLLECT};
  - slot index localparams SLOT0..SLOT3.
- One sub-module, tdm_slot_counter: a 2-bit counter with load-to-1 on sync, increment on valid, and clear on completion. It drives c1/c0 and the last-slot flag.
- Shadow registers, output registers and the FSM live in tdm_demux4.

Test Plan (all cases use WIDTH=1):
- Nominal frame:
  - Stimulus: beats (sync,m)=(1,1),(0,1),(0,0),(0,0) on consecutive cycles.
  - Response: x0..x3=1,1,0,0 one cycle after beat 4; frame_valid high for 1 cycle; c1c0 sequence 00,01,10,11,00.
- Stalls plus back-to-back frames:
  - Stimulus: frame 1,1,0,1 with valid_in low for 3 cycles between beats 2 and 3. It is followed immediately by frame 1,0,0,1 starting with sync.
  - Response: outputs 1,1,0,1 and then 1,0,0,1; two frame_valid pulses, with no error.
- Early sync:
  - Stimulus: frame started with m=1,1, then a sync beat m=0 at slot 2, then 1,0,1.
  - Response: frame_err pulse; x unchanged at 0; then x0..x3=0,1,0,1 with frame_valid.
- Hunt discard:
  - Stimulus: from reset, valid beats without sync m=1,1,1, then sync frame 0,0,1,0.
  - Response: no pulses and c1c0=00 during the unsynced beats; final x0..x3=0,0,1,0.
- Reset mid-frame:
  - Stimulus: after outputs equal 1,1,0,0, start a new frame with 2 beats, pulse rst_n low asynchronously, then send frame 0,1,1,0.
  - Response: x0..x3=0 and c1c0=00 immediately; no pulse from the partial frame; final x0..x3=0,1,1,0.
